// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the word-addressed data memory.
// Port 0 is the pipeline MEM stage, port 1 the loader/debug port; out-of-range addresses raise a sticky fault.
module dmem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fault,
    output logic [31:0]       fault_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                fault_q, fault_d;
    logic [31:0]         fault_addr_q, fault_addr_d;

    logic                p0_req;
    logic                grant1;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [DATA_W-1:0]   req_wdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        // On a tie the port that did not win last time gets the grant.
        p0_req    = p0_read | p0_write;
        grant1    = p1_req & (~p0_req | ~last_grant_q);
        req_we    = grant1 ? p1_we    : p0_write;
        req_addr  = grant1 ? p1_addr  : p0_addr;
        req_wdata = grant1 ? p1_wdata : p0_wdata;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    port_d       = grant1;
                    we_d         = req_we;
                    last_grant_d = grant1;
                    if ((req_addr >> ADDR_W) != 32'd0) begin
                        // Out-of-range: never reaches the memory, completes straight away.
                        fault_d = 1'b1;
                        if (!fault_q) begin
                            fault_addr_d = req_addr;
                        end
                        if (!req_we) begin
                            if (grant1) begin
                                p1_rdata_d = '0;
                            end else begin
                                p0_rdata_d = '0;
                            end
                        end
                        state_d = DONE;
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr[ADDR_W-1:0];
                        mem_wdata_d = req_wdata;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = 2'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    if (port_q) begin
                        p1_rdata_d = mem_rdata;
                    end else begin
                        p0_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign p0_done    = (state_q == DONE) && !port_q;
    assign p1_done    = (state_q == DONE) && port_q;
    assign p0_stall   = (p0_read | p0_write) & ~p0_done;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: four instances (MEM_LATENCY 1..4), each with its own memory model.
// Expected completions are queued per port when a request is driven and checked when done pulses.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        p0_read   [4];
    logic        p0_write  [4];
    logic [31:0] p0_addr   [4];
    logic [31:0] p0_wdata  [4];
    logic [31:0] p0_rdata  [4];
    logic        p0_done   [4];
    logic        p0_stall  [4];
    logic        p1_req    [4];
    logic        p1_we     [4];
    logic [31:0] p1_addr   [4];
    logic [31:0] p1_wdata  [4];
    logic [31:0] p1_rdata  [4];
    logic        p1_done   [4];
    logic        mem_en    [4];
    logic        mem_we    [4];
    logic [9:0]  mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic [31:0] mem_rdata [4];
    logic        fault     [4];
    logic [31:0] fault_addr[4];

    int n_assert = 0;
    int n_fail   = 0;
    int p0_done_cnt = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          rd;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        logic [31:0] mem  [1024];
        logic [31:0] pipe [g+1];

        dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LATENCY(g+1)) dut (
            .clk(clk), .reset(reset),
            .p0_read(p0_read[g]), .p0_write(p0_write[g]), .p0_addr(p0_addr[g]),
            .p0_wdata(p0_wdata[g]), .p0_rdata(p0_rdata[g]), .p0_done(p0_done[g]),
            .p0_stall(p0_stall[g]),
            .p1_req(p1_req[g]), .p1_we(p1_we[g]), .p1_addr(p1_addr[g]),
            .p1_wdata(p1_wdata[g]), .p1_rdata(p1_rdata[g]), .p1_done(p1_done[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .fault(fault[g]), .fault_addr(fault_addr[g])
        );

        // Synchronous RAM followed by g extra pipeline stages: data for the issued
        // address is valid g+1 cycles after the issue cycle.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= mem[mem_addr[g]];
            for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[g];
    end

    always @(posedge clk) begin
        if (p0_done[0]) p0_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One access on one port of one instance; cycle n is sampled at the n-th negedge after driving.
    task automatic do_access(input string tag, input int inst, input bit port, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input int exp_cyc, input bit exp_en);
        exp_t e;
        exp_t got;
        int   en_cyc = 0;
        int   stall_bad = 0;
        bit   seen = 0;
        @(negedge clk);
        e.cyc = exp_cyc; e.data = exp_rdata; e.rd = !we;
        if (port) begin
            sb1.push_back(e);
            p1_req[inst] = 1'b1; p1_we[inst] = we; p1_addr[inst] = addr; p1_wdata[inst] = wdata;
        end else begin
            sb0.push_back(e);
            p0_read[inst] = !we; p0_write[inst] = we; p0_addr[inst] = addr; p0_wdata[inst] = wdata;
        end
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_en[inst] && en_cyc == 0) en_cyc = n;
            if (!port && (p0_stall[inst] !== !p0_done[inst])) stall_bad++;
            if (port ? p1_done[inst] : p0_done[inst]) begin
                seen = 1;
                got = port ? sb1.pop_front() : sb0.pop_front();
                check({tag, "_done_cycle"}, n, got.cyc);
                if (got.rd) check({tag, "_rdata"}, port ? p1_rdata[inst] : p0_rdata[inst], got.data);
                if (port) p1_req[inst] = 1'b0;
                else begin p0_read[inst] = 1'b0; p0_write[inst] = 1'b0; end
            end
        end
        check({tag, "_completed"}, 32'(seen), 32'd1);
        if (!seen) begin
            sb0.delete(); sb1.delete();
            p1_req[inst] = 1'b0; p0_read[inst] = 1'b0; p0_write[inst] = 1'b0;
        end
        check({tag, "_mem_en_cycle"}, en_cyc, exp_en ? 32'd1 : 32'd0);
        if (!port) check({tag, "_stall"}, stall_bad, 32'd0);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        int   done0 = 0;
        int   done1 = 0;
        int   cnt_before;

        for (int i = 0; i < 4; i++) begin
            p0_read[i] = 0; p0_write[i] = 0; p0_addr[i] = 0; p0_wdata[i] = 0;
            p1_req[i] = 0; p1_we[i] = 0; p1_addr[i] = 0; p1_wdata[i] = 0;
        end
        apply_reset();

        // Reset state
        #1;
        check("rst_mem_en", 32'(mem_en[0]), 32'd0);
        check("rst_p0_done", 32'(p0_done[0]), 32'd0);
        check("rst_p0_stall", 32'(p0_stall[0]), 32'd0);
        check("rst_p0_rdata", p0_rdata[0], 32'd0);
        check("rst_fault", 32'(fault[0]), 32'd0);
        check("rst_fault_addr", fault_addr[0], 32'd0);

        // Single write / read
        do_access("wr5", 0, 0, 1, 32'd5, 32'hDEADBEEF, 32'd0, 2, 1);
        do_access("rd5", 0, 0, 0, 32'd5, 32'd0, 32'hDEADBEEF, 3, 1);
        do_access("wr1", 0, 0, 1, 32'd1, 32'h11111111, 32'd0, 2, 1);

        // Simultaneous requests right after reset
        apply_reset();
        @(negedge clk);
        e.cyc = 3;  e.data = 32'h11111111; e.rd = 1; sb0.push_back(e);
        e.cyc = 6;  e.data = 32'd0;        e.rd = 0; sb1.push_back(e);
        e.cyc = 10; e.data = 32'hCAFE0002; e.rd = 1; sb0.push_back(e);
        p0_read[0] = 1; p0_addr[0] = 32'd1;
        p1_req[0] = 1; p1_we[0] = 1; p1_addr[0] = 32'd2; p1_wdata[0] = 32'hCAFE0002;
        for (int n = 1; n <= 30 && (sb0.size() + sb1.size()) != 0; n++) begin
            @(negedge clk);
            if (n == 5) check("tie_p0_stall_waiting", 32'(p0_stall[0]), 32'd1);
            if (p0_done[0]) begin
                got = sb0.pop_front();
                done0++;
                check("tie_p0_done_cycle", n, got.cyc);
                check("tie_p0_rdata", p0_rdata[0], got.data);
                if (done0 == 1) p0_addr[0] = 32'd2;
                else p0_read[0] = 0;
            end
            if (p1_done[0]) begin
                got = sb1.pop_front();
                done1++;
                check("tie_p1_done_cycle", n, got.cyc);
                p1_req[0] = 0;
            end
        end
        check("tie_all_done", sb0.size() + sb1.size(), 32'd0);
        sb0.delete(); sb1.delete();
        p0_read[0] = 0; p1_req[0] = 0;

        // Latency sweep
        for (int i = 0; i < 4; i++) begin
            do_access($sformatf("lat%0d_wr", i+1), i, 0, 1, 32'd9, 32'h1000 + i, 32'd0, 2, 1);
            do_access($sformatf("lat%0d_rd", i+1), i, 0, 0, 32'd9, 32'd0, 32'h1000 + i, 3 + i, 1);
        end

        // Out-of-range accesses
        do_access("p1_rd5", 0, 1, 0, 32'd5, 32'd0, 32'hDEADBEEF, 3, 1);
        do_access("oor_400", 0, 1, 0, 32'h400, 32'd0, 32'd0, 1, 0);
        #1;
        check("oor_fault", 32'(fault[0]), 32'd1);
        check("oor_fault_addr", fault_addr[0], 32'h400);
        do_access("oor_800", 0, 0, 1, 32'h800, 32'h5555, 32'd0, 1, 0);
        #1;
        check("oor_fault_addr_kept", fault_addr[0], 32'h400);

        // Reset asserted during WAIT
        @(negedge clk);
        p0_read[0] = 1; p0_addr[0] = 32'd5;
        repeat (2) @(negedge clk);
        cnt_before = p0_done_cnt;
        reset = 1'b1;
        p0_read[0] = 0;
        #1;
        check("midrst_mem_en", 32'(mem_en[0]), 32'd0);
        check("midrst_p0_done", 32'(p0_done[0]), 32'd0);
        check("midrst_p0_stall", 32'(p0_stall[0]), 32'd0);
        check("midrst_p1_rdata", p1_rdata[0], 32'd0);
        check("midrst_fault", 32'(fault[0]), 32'd0);
        check("midrst_fault_addr", fault_addr[0], 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("midrst_no_done_pulse", p0_done_cnt, cnt_before);
        check("midrst_p0_rdata", p0_rdata[0], 32'd0);
        do_access("post_rst_rd5", 0, 0, 0, 32'd5, 32'd0, 32'hDEADBEEF, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
